// File: rtl/tc08_block_sequencer.sv
// tc08_block_sequencer: walks the forward DECtape block format from decoded mark-track events,
// opening the data window, counting words and blocks, and flagging sequence, count and timeout errors.
module tc08_block_sequencer #(
    parameter int WORDS   = 129,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        tape_strobe_i,
    input  logic        mark_valid_i,
    input  logic [2:0]  mark_code_i,
    input  logic        go_i,
    input  logic        stop_i,
    input  logic        cont_i,
    output logic [2:0]  state_o,
    output logic        busy_o,
    output logic        data_window_o,
    output logic [7:0]  word_cnt_o,
    output logic [11:0] blk_cnt_o,
    output logic        zero_w_o,
    output logic        blk_done_o,
    output logic        mark_err_o,
    output logic        timeout_o
);
    typedef enum logic [2:0] {IDLE, ARMED, BLKNUM, REVCK, DATA, FINAL, CK} state_t;
    localparam logic [2:0] M_BLK_END = 3'd1, M_BLK_MK = 3'd3, M_DSYNC = 3'd4, M_DATA = 3'd5, M_END = 3'd6;
    state_t      state_q, state_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [11:0] bcnt_q, bcnt_d;
    logic [9:0]  scnt_q, scnt_d;
    logic        err_q, err_d, zw_q, bd_q;
    logic        active, mk, expire, acc, done, bad;
    always_comb begin
        active  = state_q != IDLE;
        mk      = mark_valid_i && mark_code_i != 3'd0;
        expire  = active && tape_strobe_i && !stop_i && scnt_q == 10'(TIMEOUT - 1);
        state_d = state_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;
        err_d   = err_q;
        scnt_d  = (active && tape_strobe_i) ? scnt_q + 10'd1 : scnt_q;
        acc     = 1'b0;
        done    = 1'b0;
        bad     = 1'b0;
        if (stop_i) begin
            state_d = IDLE;
        end else if (expire) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else if (mk && active) begin
            case (state_q)
                ARMED: begin
                    acc     = mark_code_i == M_BLK_MK;
                    state_d = acc ? BLKNUM : ARMED;
                end
                BLKNUM: begin
                    acc     = mark_code_i == M_DSYNC;
                    state_d = REVCK;
                end
                REVCK: begin
                    acc     = mark_code_i == M_DATA;
                    state_d = DATA;
                    wcnt_d  = 8'd1;
                end
                DATA: begin
                    // overrun and underrun both fall out as "not the expected mark"
                    if (mark_code_i == M_DATA && wcnt_q < 8'(WORDS)) begin
                        acc    = 1'b1;
                        wcnt_d = wcnt_q + 8'd1;
                    end else begin
                        acc     = mark_code_i == M_END && wcnt_q == 8'(WORDS);
                        state_d = FINAL;
                    end
                end
                FINAL: begin
                    acc     = mark_code_i == M_DSYNC;
                    state_d = CK;
                end
                CK: begin
                    acc     = mark_code_i == M_BLK_END;
                    done    = acc;
                    bcnt_d  = bcnt_q + 12'd1;
                    state_d = cont_i ? ARMED : IDLE;
                    wcnt_d  = cont_i ? 8'd0 : wcnt_q;
                end
                default: ;
            endcase
            bad = !acc && state_q != ARMED;
            if (!acc) begin
                state_d = bad ? IDLE : state_q;
                wcnt_d  = wcnt_q;
                bcnt_d  = bcnt_q;
                err_d   = err_q | bad;
            end
        end else if (go_i && !active) begin
            state_d = ARMED;
            err_d   = 1'b0;
            wcnt_d  = 8'd0;
        end
        if (acc || state_d == IDLE || (go_i && !active)) scnt_d = 10'd0;
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            wcnt_q  <= 8'd0;
            bcnt_q  <= 12'd0;
            scnt_q  <= 10'd0;
            err_q   <= 1'b0;
            zw_q    <= 1'b0;
            bd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            scnt_q  <= scnt_d;
            err_q   <= err_d;
            zw_q    <= acc;
            bd_q    <= done;
        end
    end
    assign state_o       = state_q;
    assign busy_o        = state_q != IDLE;
    assign data_window_o = state_q == REVCK || state_q == DATA;
    assign word_cnt_o    = wcnt_q;
    assign blk_cnt_o     = bcnt_q;
    assign zero_w_o      = zw_q;
    assign blk_done_o    = bd_q;
    assign mark_err_o    = err_q;
    assign timeout_o     = expire;
endmodule

// File: tb/tb_tc08_block_sequencer.sv
// tb_tc08_block_sequencer: directed and random mark streams checked against a block-position model.
module tb_tc08_block_sequencer;
    localparam int W = 4, TO = 8;
    logic clk = 0, reset = 1, strobe = 0, mv = 0, go = 0, stop = 0, cont = 0;
    logic [2:0] code = 0;
    logic [2:0] state;
    logic busy, window, zero_w, blk_done, mark_err, timeout;
    logic [7:0] word_cnt;
    logic [11:0] blk_cnt;
    int compared = 0, mismatched = 0, zw_seen = 0;
    bit m_busy, m_err, m_zw, m_bd;
    int pos, m_wc, m_bc, m_scnt;

    tc08_block_sequencer #(.WORDS(W), .TIMEOUT(TO)) dut (
        .clk_i(clk), .reset_i(reset), .tape_strobe_i(strobe), .mark_valid_i(mv),
        .mark_code_i(code), .go_i(go), .stop_i(stop), .cont_i(cont),
        .state_o(state), .busy_o(busy), .data_window_o(window), .word_cnt_o(word_cnt),
        .blk_cnt_o(blk_cnt), .zero_w_o(zero_w), .blk_done_o(blk_done),
        .mark_err_o(mark_err), .timeout_o(timeout));

    always #5 clk = ~clk;

    // pos = marks accepted so far in the current block; the block format is a fixed list of codes
    function automatic int exp_code(int p);
        if (p == 0) return 3;
        if (p == 1) return 4;
        if (p <= W + 1) return 5;
        if (p == W + 2) return 6;
        if (p == W + 3) return 4;
        return 1;
    endfunction

    function automatic int m_state();
        if (!m_busy) return 0;
        if (pos < 3) return pos + 1;
        if (pos <= W + 2) return 4;
        return pos - W + 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input int expv);
        compared++;
        assert (obs === 32'(expv)) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_outs();
        int s = m_state();
        chk("state", 32'(state), s);
        chk("busy", 32'(busy), int'(m_busy));
        chk("data_window", 32'(window), int'(s == 3 || s == 4));
        chk("word_cnt", 32'(word_cnt), m_wc);
        chk("blk_cnt", 32'(blk_cnt), m_bc);
        chk("zero_w", 32'(zero_w), int'(m_zw));
        chk("blk_done", 32'(blk_done), int'(m_bd));
        chk("mark_err", 32'(mark_err), int'(m_err));
        if (zero_w === 1'b1) zw_seen++;
    endtask

    task automatic model_reset();
        m_busy = 0; m_err = 0; m_zw = 0; m_bd = 0; pos = 0; m_wc = 0; m_bc = 0; m_scnt = 0;
    endtask

    task automatic cyc(input bit s, input bit v, input int c, input bit g, input bit sp, input bit ct);
        bit to, mk, acc, done, gstart;
        int ns;
        @(negedge clk);
        strobe = s; mv = v; code = 3'(c); go = g; stop = sp; cont = ct;
        #1;
        to = m_busy && s && m_scnt == TO - 1 && !sp;
        chk("timeout", 32'(timeout), int'(to));
        @(posedge clk);
        mk = v && c != 0; acc = 0; done = 0; gstart = 0;
        ns = (m_busy && s) ? m_scnt + 1 : m_scnt;
        if (sp) m_busy = 0;
        else if (to) begin m_busy = 0; m_err = 1; end
        else if (mk && m_busy) begin
            if (c == exp_code(pos)) begin
                acc = 1; pos++;
                if (c == 5) m_wc = pos - 2;
                if (pos == W + 5) begin
                    done = 1; m_bc = (m_bc + 1) % 4096; pos = 0;
                    if (ct) m_wc = 0; else m_busy = 0;
                end
            end else if (pos != 0) begin m_err = 1; m_busy = 0; end
        end else if (g && !m_busy) begin m_busy = 1; pos = 0; m_err = 0; m_wc = 0; gstart = 1; end
        if (acc || gstart || !m_busy) ns = 0;
        m_scnt = ns; m_zw = acc; m_bd = done;
        #1;
        chk_outs();
    endtask

    task automatic mark(input int c, input bit ct);
        cyc(0, 1, c, 0, 0, ct);
    endtask

    task automatic start();
        cyc(0, 0, 0, 1, 0, 0);
    endtask

    task automatic block(input bit ct);
        mark(3, ct); mark(4, ct);
        for (int i = 0; i < W; i++) mark(5, ct);
        mark(6, ct); mark(4, ct); mark(1, ct);
    endtask

    initial begin
        model_reset();
        #2 chk_outs();
        chk("timeout", 32'(timeout), 0);
        @(negedge clk) reset = 0;
        // clean block, no re-arm
        start(); zw_seen = 0; block(0);
        chk("zw_count", 32'(zw_seen), W + 5);
        // hunting marks then continuous blocks
        start(); mark(5, 1); mark(6, 1);
        for (int b = 0; b < 3; b++) block(1);
        cyc(0, 0, 0, 0, 1, 0);
        // underrun then overrun
        start(); mark(3, 0); mark(4, 0);
        for (int i = 0; i < W - 1; i++) mark(5, 0);
        mark(6, 0);
        start(); mark(3, 0); mark(4, 0);
        for (int i = 0; i <= W; i++) mark(5, 0);
        // sequence error, then go clears mark_err
        start(); mark(3, 0); mark(4, 0); mark(2, 0);
        start(); cyc(0, 0, 0, 0, 1, 0);
        // timeout boundary
        start();
        for (int i = 0; i < TO; i++) cyc(1, 0, 0, 0, 0, 0);
        start();
        for (int i = 0; i < TO - 1; i++) cyc(1, 0, 0, 0, 0, 0);
        mark(3, 0);
        for (int i = 0; i < TO - 1; i++) cyc(1, 0, 0, 0, 0, 0);
        // timeout collides with a mark
        cyc(1, 1, 4, 0, 0, 0);
        // stop beats a same-cycle DATA mark
        start(); mark(3, 0); mark(4, 0); mark(5, 0); mark(5, 0);
        cyc(0, 1, 5, 0, 1, 0);
        // asynchronous reset while in CK
        start(); mark(3, 0); mark(4, 0);
        for (int i = 0; i < W; i++) mark(5, 0);
        mark(6, 0); mark(4, 0);
        @(negedge clk); strobe = 0; mv = 0; go = 0; stop = 0; cont = 0;
        #2 reset = 1;
        #1 model_reset();
        chk_outs();
        chk("timeout", 32'(timeout), 0);
        @(negedge clk) reset = 0;
        // random streams, biased toward the expected next mark
        for (int n = 0; n < 4000; n++) begin
            int c;
            c = ($urandom_range(0, 9) < 7) ? exp_code(pos) : int'($urandom_range(0, 7));
            cyc($urandom_range(0, 99) < 15, 1'($urandom_range(0, 1)), c,
                $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
